composite_sync_generator: RTL
=============================

Name: composite_sync_generator

Overview:
Generates composite-video DAC samples with embedded sync. It is the transmit-side counterpart of the sync separator: it emits H-sync tips, V-sync broad pulses and blanking levels, and passes through active pixels. It sits between the upscaler's frame reader and the video DAC, advancing one sample per sample_valid strobe (~37 MHz). Its timing lets the sync separator relock to its own output in loopback.

Parameters:
LINE_TOTAL, 2368, samples per line (~64 us)
HSYNC_WIDTH, 175, sync tip samples per normal line (~4.7 us)
BACK_PORCH, 175, blank samples between sync end and active start
ACTIVE_WIDTH, 1920, active samples per line
LINES_PER_FRAME, 262, lines per frame
VSYNC_LINES, 3, broad-pulse lines at frame start (lines 0..VSYNC_LINES-1)
EQ_LINES, 3, equalizing lines after broad lines (used only with the optional feature)
SYNC_LEVEL, 0, DAC code for sync tip
BLANK_LEVEL, 1024, DAC code for blank/black; floor for active pixels

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
sample_valid  in  1  one-clk strobe; all state advances only on it
enable  in  1  run/hold generator
pixel_data  in  12  active pixel code; sampled on a strobe while pixel_req=1
pixel_req  out  1  combinational; high when the current sample is active video
dac_out  out  12  registered DAC code
h_sync_pulse  out  1  one-clk pulse at each line start
v_sync_pulse  out  1  one-clk pulse at frame start
x_coord  out  12  active pixel index; 0 outside active
y_coord  out  10  current line number

Behaviour:
- Reset values: h_cnt=0, v_cnt=0, dac_out=BLANK_LEVEL, h_sync_pulse=0, v_sync_pulse=0. Outputs derived from the counters read pixel_req=0, x_coord=0, y_coord=0.
- Elaboration check: HSYNC_WIDTH+BACK_PORCH+ACTIVE_WIDTH < LINE_TOTAL, and VSYNC_LINES+EQ_LINES < LINES_PER_FRAME.
- Pulses default to 0 every clk. With no strobe, all state holds.
- On a strobe with enable=1, let c=h_cnt and v=v_cnt:
  - dac_out <= level(c,v).
  - h_cnt <= c+1, wrapping to 0 at LINE_TOTAL-1.
  - On wrap, v_cnt <= v+1, wrapping to 0 at LINES_PER_FRAME-1.
  - h_sync_pulse <= (c==0).
  - v_sync_pulse <= (c==0 && v==0).
- Latency: dac_out, h_sync_pulse and v_sync_pulse appear one clk after the strobe that computed them.
- Line types:
  - BROAD when v<VSYNC_LINES.
  - EQUALIZE (feature only) when VSYNC_LINES<=v<VSYNC_LINES+EQ_LINES.
  - NORMAL otherwise.
- level() for NORMAL lines, per-line FSM regions:
  - SYNC: c<HSYNC_WIDTH, SYNC_LEVEL.
  - BACK_PORCH: c<HSYNC_WIDTH+BACK_PORCH, BLANK_LEVEL.
  - ACTIVE: c<HSYNC_WIDTH+BACK_PORCH+ACTIVE_WIDTH, max(pixel_data, BLANK_LEVEL).
  - FRONT_PORCH: otherwise, BLANK_LEVEL.
- level() for BROAD lines: SYNC_LEVEL for c<LINE_TOTAL-HSYNC_WIDTH, else BLANK_LEVEL (serration). No active region on BROAD lines.
- pixel_req and x_coord: pixel_req=1 only in the ACTIVE region of NORMAL lines. There, x_coord = c-(HSYNC_WIDTH+BACK_PORCH), range 0..ACTIVE_WIDTH-1. y_coord = v.
- enable=0, applied synchronously on the next clk whether or not a strobe is present: h_cnt=0, v_cnt=0, dac_out=BLANK_LEVEL, no pulses. When enable returns to 1, the next strobe starts at line 0, sample 0 and fires v_sync_pulse.
- Deasserting enable or asserting rst mid-line or mid-frame aborts immediately. No partial-line completion.
- Counter widths: h_cnt 12 bits, v_cnt 10 bits. No overflow, because wrap occurs at the parameter limits.

Optional Feature:
- Macro: COMPOSITE_EQ_PULSES_EN.
- Defined: EQUALIZE lines output SYNC_LEVEL for c<HSYNC_WIDTH/2 and for LINE_TOTAL/2<=c<LINE_TOTAL/2+HSYNC_WIDTH/2, and BLANK_LEVEL elsewhere. pixel_req=0 on these lines. h_sync_pulse fires only at c=0.
- Not defined: those lines are NORMAL lines and EQ_LINES is ignored.

Test Plan:
- Reset, then enable=1 with continuous strobes -> dac_out=1024 before the first strobe. v_sync_pulse and h_sync_pulse high 1 clk after the first strobe. Line 0 outputs 2193 samples of 0, then 175 samples of 1024.
- Line 3 with pixel_data=0x800 -> 175 samples of 0, 175 of 1024, 1920 of 0x800 with x_coord 0..1919 and pixel_req=1, then 98 of 1024. pixel_data=0x100 in active -> dac_out=1024 (clamped).
- Run 262*2368 strobes -> v_sync_pulse exactly once per frame, h_sync_pulse 262 times, y_coord wraps 261->0.
- Strobe every 3rd clk -> identical sample sequence. All outputs hold between strobes. Pulses are 1 clk wide.
- enable dropped at line 10, c=500; rst asserted during active on a later line -> immediate dac_out=1024 and counters 0. Restart begins a fresh frame at line 0.
- With COMPOSITE_EQ_PULSES_EN: lines 3..5 carry 87-sample tips at c=0 and c=1184, with no pixel_req. Without the macro, line 3 is a normal line.

Source files
------------

// File: rtl/composite_sync_generator.sv
// Composite-video sample generator: sync tips, broad V-sync pulses, blanking and clamped active pixels.
// Optional equalizing pulses on the lines after the broad pulses are built when COMPOSITE_EQ_PULSES_EN is defined.
module composite_sync_generator #(
    parameter int LINE_TOTAL      = 2368,
    parameter int HSYNC_WIDTH     = 175,
    parameter int BACK_PORCH      = 175,
    parameter int ACTIVE_WIDTH    = 1920,
    parameter int LINES_PER_FRAME = 262,
    parameter int VSYNC_LINES     = 3,
    parameter int EQ_LINES        = 3,
    parameter int SYNC_LEVEL      = 0,
    parameter int BLANK_LEVEL     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic        enable,
    input  logic [11:0] pixel_data,
    output logic        pixel_req,
    output logic [11:0] dac_out,
    output logic        h_sync_pulse,
    output logic        v_sync_pulse,
    output logic [11:0] x_coord,
    output logic [9:0]  y_coord
);

    if ((HSYNC_WIDTH + BACK_PORCH + ACTIVE_WIDTH >= LINE_TOTAL) ||
        (VSYNC_LINES + EQ_LINES >= LINES_PER_FRAME)) begin : g_bad_params
        $error("composite_sync_generator: line or frame timing does not fit");
    end

    localparam logic [11:0] H_LAST      = 12'(LINE_TOTAL - 1);
    localparam logic [11:0] SYNC_END    = 12'(HSYNC_WIDTH);
    localparam logic [11:0] BP_END      = 12'(HSYNC_WIDTH + BACK_PORCH);
    localparam logic [11:0] ACT_END     = 12'(HSYNC_WIDTH + BACK_PORCH + ACTIVE_WIDTH);
    localparam logic [11:0] SERR_START  = 12'(LINE_TOTAL - HSYNC_WIDTH);
    localparam logic [9:0]  V_LAST      = 10'(LINES_PER_FRAME - 1);
    localparam logic [9:0]  V_BROAD_END = 10'(VSYNC_LINES);
    localparam logic [11:0] SYNC_CODE   = 12'(SYNC_LEVEL);
    localparam logic [11:0] BLANK_CODE  = 12'(BLANK_LEVEL);
`ifdef COMPOSITE_EQ_PULSES_EN
    localparam logic [9:0]  V_EQ_END    = 10'(VSYNC_LINES + EQ_LINES);
    localparam logic [11:0] EQ_TIP_END  = 12'(HSYNC_WIDTH / 2);
    localparam logic [11:0] HALF_LINE   = 12'(LINE_TOTAL / 2);
    localparam logic [11:0] HALF_TIP_END = 12'(LINE_TOTAL / 2 + HSYNC_WIDTH / 2);
`endif

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [11:0] dac_q, dac_d;
    logic        h_pulse_q, h_pulse_d;
    logic        v_pulse_q, v_pulse_d;
    logic [11:0] level;
    logic        line_broad;

    // Active pixels never dip below black so they cannot be mistaken for sync.
    function automatic logic [11:0] clamp_black(input logic [11:0] code);
        return (code < BLANK_CODE) ? BLANK_CODE : code;
    endfunction

    assign line_broad = (v_cnt_q < V_BROAD_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            dac_q     <= BLANK_CODE;
            h_pulse_q <= 1'b0;
            v_pulse_q <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            dac_q     <= dac_d;
            h_pulse_q <= h_pulse_d;
            v_pulse_q <= v_pulse_d;
        end
    end

    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        dac_d     = dac_q;
        h_pulse_d = 1'b0;
        v_pulse_d = 1'b0;
        if (!enable) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            dac_d   = BLANK_CODE;
        end else if (sample_valid) begin
            dac_d     = level;
            h_pulse_d = (h_cnt_q == 12'd0);
            v_pulse_d = (h_cnt_q == 12'd0) && (v_cnt_q == 10'd0);
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
            end
        end
    end

    // Region decode of the current sample; drives the next DAC code and the pixel request.
    always_comb begin
        level     = BLANK_CODE;
        pixel_req = 1'b0;
        x_coord   = '0;
        if (line_broad) begin
            level = (h_cnt_q < SERR_START) ? SYNC_CODE : BLANK_CODE;
        end
`ifdef COMPOSITE_EQ_PULSES_EN
        else if (v_cnt_q < V_EQ_END) begin
            if ((h_cnt_q < EQ_TIP_END) ||
                ((h_cnt_q >= HALF_LINE) && (h_cnt_q < HALF_TIP_END)))
                level = SYNC_CODE;
        end
`endif
        else if (h_cnt_q < SYNC_END) begin
            level = SYNC_CODE;
        end else if (h_cnt_q < BP_END) begin
            level = BLANK_CODE;
        end else if (h_cnt_q < ACT_END) begin
            level     = clamp_black(pixel_data);
            pixel_req = 1'b1;
            x_coord   = h_cnt_q - BP_END;
        end
    end

    assign dac_out      = dac_q;
    assign h_sync_pulse = h_pulse_q;
    assign v_sync_pulse = v_pulse_q;
    assign y_coord      = v_cnt_q;

endmodule
